// File: rtl/halflife_pkg.sv
// Shared types and default constants for the half-life timer sequencer.
package halflife_pkg;

    localparam int HL_WIDTH    = 4;
    localparam int HL_PRESCALE = 1000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        DECAY = 3'd3,
        DONE  = 3'd4
    } hl_state_t;

endpackage

// File: rtl/halflife_if.sv
// Control/status bundle between the pin-mapping layer (master) and the sequencer (slave).
interface halflife_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] period;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_down;
    logic             cnt_up;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] halvings;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, init_val, period,
        input  cnt_load, cnt_load_val, cnt_down, cnt_up, value, halvings, busy, done, err
    );

    modport slave (
        input  start, abort, init_val, period,
        output cnt_load, cnt_load_val, cnt_down, cnt_up, value, halvings, busy, done, err
    );
endinterface

// File: rtl/halflife_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE cycles, phase reset by a synchronous restart.
module halflife_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the last phase, forced to zero by restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/halflife_ctrl.sv
// Half-life sequencer: loads the counter, then after each period issues a floor-halving burst of down strobes.
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int WIDTH    = HL_WIDTH,
    parameter int PRESCALE = HL_PRESCALE
) (
    input  logic       clk,
    input  logic       rst_n,
    halflife_if.slave  bus
);
    hl_state_t        state_q, state_d;
    logic [WIDTH-1:0] init_q, init_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] halv_q, halv_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             load_q, load_d;
    logic             down_q, down_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tick_s;
    logic             restart_s;

    // Prescaler phase is held at zero everywhere but WAIT, so each WAIT starts a full period.
    assign restart_s = (state_q != WAIT);

    halflife_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state, datapath and output strobe computation.
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        period_d = period_q;
        tcnt_d   = tcnt_q;
        rem_d    = rem_q;
        value_d  = value_q;
        halv_d   = halv_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.period != '0) begin
                        init_d   = bus.init_val;
                        period_d = bus.period;
                        halv_d   = '0;
                        err_d    = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                value_d = init_q;
                tcnt_d  = '0;
                state_d = (init_q == '0) ? DONE : WAIT;
            end
            WAIT: begin
                if (tick_s) begin
                    if (tcnt_q == period_q - WIDTH'(1)) begin
                        rem_d   = value_q - (value_q >> 1);
                        state_d = DECAY;
                    end else begin
                        tcnt_d = tcnt_q + WIDTH'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            DECAY: begin
                value_d = value_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    halv_d  = (halv_q == '1) ? halv_q : halv_q + WIDTH'(1);
                    tcnt_d  = '0;
                    state_d = (value_q == WIDTH'(1)) ? DONE : WAIT;
                end else begin
                    rem_d = rem_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the pulse issued this cycle in value but nothing else of the run's progress.
        if (bus.abort) begin
            state_d = IDLE;
            err_d   = 1'b0;
            halv_d  = halv_q;
            value_d = (state_q == DECAY) ? value_q - WIDTH'(1) : value_q;
        end else begin
            err_d = err_d;
        end

        load_d     = (state_d == LOAD);
        load_val_d = load_d ? init_d : '0;
        down_d     = (state_d == DECAY);
        busy_d     = (state_d == LOAD) || (state_d == WAIT) || (state_d == DECAY);
        done_d     = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            init_q     <= '0;
            period_q   <= '0;
            tcnt_q     <= '0;
            rem_q      <= '0;
            value_q    <= '0;
            halv_q     <= '0;
            load_val_q <= '0;
            load_q     <= 1'b0;
            down_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            period_q   <= period_d;
            tcnt_q     <= tcnt_d;
            rem_q      <= rem_d;
            value_q    <= value_d;
            halv_q     <= halv_d;
            load_val_q <= load_val_d;
            load_q     <= load_d;
            down_q     <= down_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.cnt_load     = load_q;
    assign bus.cnt_load_val = load_val_q;
    assign bus.cnt_down     = down_q;
    assign bus.cnt_up       = 1'b0;
    assign bus.value        = value_q;
    assign bus.halvings     = halv_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_halflife_ctrl.sv
// Directed and random bench for halflife_ctrl against a cycle-list model of the half-life run.
module tb_halflife_ctrl;
    localparam int W  = 4;
    localparam int PS = 2;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    halflife_if #(.WIDTH(W)) bus ();

    halflife_ctrl #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, 32'(bus.cnt_load), 0);
        chk({tag, "_lval"}, 32'(bus.cnt_load_val), 0);
        chk({tag, "_down"}, 32'(bus.cnt_down), 0);
        chk({tag, "_up"}, 32'(bus.cnt_up), 0);
        chk({tag, "_value"}, 32'(bus.value), 0);
        chk({tag, "_halv"}, 32'(bus.halvings), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask

    // One full run: model lists the down-strobe level for every cycle after LOAD.
    task automatic run(input int init, input int per, input int poke);
        bit q[$];
        int v, h, d, mv;
        v = init;
        h = 0;
        while (v != 0) begin
            repeat (per * PS) q.push_back(1'b0);
            d = v - v / 2;
            repeat (d) q.push_back(1'b1);
            v = v - d;
            h = (h == 15) ? 15 : h + 1;
        end
        bus.init_val = W'(init);
        bus.period   = W'(per);
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("load", 32'(bus.cnt_load), 1);
        chk("load_val", 32'(bus.cnt_load_val), 32'(init));
        chk("busy_load", 32'(bus.busy), 1);
        chk("err_clr", 32'(bus.err), 0);
        chk("halv_clr", 32'(bus.halvings), 0);
        mv = init;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("down", 32'(bus.cnt_down), 32'(q[i]));
            chk("load_off", 32'(bus.cnt_load), 0);
            chk("lval_off", 32'(bus.cnt_load_val), 0);
            chk("value", 32'(bus.value), 32'(mv));
            chk("busy", 32'(bus.busy), 1);
            if (q[i]) mv--;
            if (i == poke) begin
                bus.start    = 1'b1;
                bus.init_val = W'(init + 5);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("done", 32'(bus.done), 1);
        chk("busy_end", 32'(bus.busy), 0);
        chk("down_end", 32'(bus.cnt_down), 0);
        chk("value_end", 32'(bus.value), 0);
        chk("halvings", 32'(bus.halvings), 32'(h));
        chk("up", 32'(bus.cnt_up), 0);
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    initial begin
        int pulses;
        bit found;
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.init_val = '0;
        bus.period   = '0;
        #1;
        chk_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        // Full run 9/2 (26 cycles LOAD to done), then zero init from DONE.
        run(9, 2, -1);
        run(0, 3, -1);

        // Invalid period from IDLE, then a valid start clears err.
        do_abort();
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        bus.period = '0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_set", 32'(bus.err), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_load", 32'(bus.cnt_load), 0);
        @(negedge clk);
        chk("err_sticky", 32'(bus.err), 1);
        chk("err_done", 32'(bus.done), 0);
        run(3, 1, -1);

        // Abort on the third pulse of a 15/1 run.
        do_abort();
        bus.init_val = 4'd15;
        bus.period   = 4'd1;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ab_load", 32'(bus.cnt_load), 1);
        pulses = 0;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.cnt_down) pulses++;
            if (pulses == 3) found = 1'b1;
        end
        chk("ab_reach", 32'(found), 1);
        do_abort();
        chk("ab_value", 32'(bus.value), 12);
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_done", 32'(bus.done), 0);
        chk("ab_err", 32'(bus.err), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ab_quiet", 32'(bus.cnt_down), 0);
        end

        // Start together with abort in IDLE stays idle; start during WAIT is ignored.
        bus.init_val = 4'd5;
        bus.period   = 4'd2;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_load", 32'(bus.cnt_load), 0);
        chk("sa_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("sa_busy2", 32'(bus.busy), 0);
        run(6, 2, 1);

        // Random runs.
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), -1);
        end

        // Asynchronous reset during a burst.
        bus.init_val = 4'd9;
        bus.period   = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.cnt_down) found = 1'b1;
        end
        chk("rst_reach", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");
        run(9, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/halflife_ctrl.md
# halflife_ctrl

Sequencer for the half-life timer's loadable up/down counter datapath. It loads a starting quantity into the counter and, after each programmed half-life period, issues a burst of single-cycle `down` pulses that halve the count (floor). It repeats until the count reaches zero, tracking the number of halvings and flagging completion. It sits between the top-level pin mapping (user start/abort, initial value, period) and the counter.

## Interface
Parameters:
- `WIDTH`, default 4: width of the counter value, initial value and period.
- `PRESCALE`, default 1000: number of `clk` cycles per timer tick. Must be at least 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level-sampled. Begins a run when in IDLE or DONE.
- `abort`, in, 1: returns to IDLE from any state. Wins over `start`.
- `init_val`, in, WIDTH: starting quantity, sampled in the cycle `start` is accepted.
- `period`, in, WIDTH: half-life length in ticks, sampled with `init_val`.
- `cnt_load`, out, 1: one-cycle load strobe to the counter.
- `cnt_load_val`, out, WIDTH: value to load. Valid while `cnt_load` is high, 0 otherwise.
- `cnt_down`, out, 1: decrement strobe. At most one decrement per cycle.
- `cnt_up`, out, 1: tied to 0. Reserved.
- `value`, out, WIDTH: shadow copy of the counter value, as the controller tracks it.
- `halvings`, out, WIDTH: number of completed halvings. Saturates at all-ones.
- `busy`, out, 1: high in LOAD, WAIT and DECAY.
- `done`, out, 1: high in DONE.
- `err`, out, 1: sticky. Set when a start is requested with `period`==0. Cleared by the next accepted start or by `abort`.

## Operation
States: IDLE, LOAD, WAIT, DECAY, DONE.

- **IDLE / DONE**
  - `start`=1, `abort`=0, `period`≠0: latch `init_val` and `period`, clear `halvings`, clear `err`, go to LOAD.
  - `start`=1 with `period`==0: set `err`, stay in the current state.
- **LOAD**
  - Drive `cnt_load`=1 and `cnt_load_val`=latched init, for one cycle.
  - Set `value` to the latched init.
  - Restart the prescaler and the tick counter.
  - If init==0, go to DONE. Otherwise go to WAIT.
- **WAIT**
  - The prescaler emits a tick every PRESCALE cycles.
  - When the tick count reaches the latched period, compute d = `value` − (`value`>>1) and go to DECAY.
- **DECAY**
  - Drive `cnt_down`=1 for exactly d consecutive cycles. Decrement `value` each cycle.
  - After the last pulse: increment `halvings` (saturating).
  - If `value`==0, go to DONE. Otherwise restart the prescaler and tick counter and go to WAIT.
- **Any state**
  - `abort`=1: go to IDLE on the next edge. From that edge on, `cnt_load` and `cnt_down` are 0. `value` and `halvings` keep their contents. `err` is cleared.
- **While busy**
  - `start` is ignored.
- **Arithmetic**
  - All arithmetic is unsigned, WIDTH bits. The tick counter is WIDTH bits. The prescaler counter is $clog2(PRESCALE) bits, minimum 1.

## Timing
- **Reset value of every output:** 0. State after reset is IDLE.
- **Start:** sampled at edge N. `cnt_load` is high during cycle N+1 (LOAD). WAIT is entered at N+2.
- **Half-life:** each WAIT lasts exactly period×PRESCALE cycles. The first DECAY pulse is in the cycle immediately after WAIT.
- **Down pulses:** back-to-back, with no gaps inside a burst.
- **Done:** `done` rises in the cycle after the final `cnt_down`. `busy` falls in the same cycle.
- **Run length:** total cycles from LOAD to DONE = 1 + (halvings × period × PRESCALE) + init.
- **Abort mid-burst:** the remaining pulses are dropped. `value` reflects the pulses actually issued.
- **Reset mid-run:** all outputs go to 0 immediately (asynchronous). No strobe may glitch high.

## Structure
- **Package `halflife_pkg`:**
  - State enum `hl_state_t` (IDLE, LOAD, WAIT, DECAY, DONE).
  - Default constants `HL_WIDTH`=4 and `HL_PRESCALE`=1000.
- **Sub-module `halflife_prescaler`:** tick generator with `clk`, `rst_n`, synchronous `restart`, output `tick` (one cycle every PRESCALE cycles after `restart`).
- **Top level:** FSM, tick counter, shadow value and halvings registers.

## Test plan
Benches use PRESCALE=2.

1. **Full run.** `init_val`=9, `period`=2, pulse `start`. Required response:
   - one `cnt_load` with value 9;
   - down bursts of 5, 2, 1 and 1 pulses, each preceded by a 4-cycle WAIT;
   - final `halvings`=4, `value`=0, `done`=1;
   - `done` rises 26 cycles after LOAD.
2. **Zero initial value.** `init_val`=0, `period`=3, `start`. Required response: one load, then `done` in the next cycle, `halvings`=0, no `cnt_down`.
3. **Invalid period.** `period`=0, `start`. Required response: `err`=1, state stays IDLE, no strobes. A later `start` with `period`=1 clears `err` and runs.
4. **Abort mid-burst.** `init_val`=15, `period`=1, `abort` on the 3rd down pulse. Required response: exactly 3 pulses issued, `value`=12, IDLE, `busy`=0.
5. **Start while busy; start with abort.** `start` while in WAIT is ignored (run timing unchanged). `start` and `abort` asserted in the same IDLE cycle leave the block in IDLE.
6. **Asynchronous reset.** Assert `rst_n`=0 during DECAY. Required response: all outputs 0 at once. After release, IDLE and a fresh run behave as in scenario 1.
